// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 scan-code sequences into per-key held flags and a press/release event FIFO
// Ports:
//   inclock, resetn              clock, synchronous active-low reset
//   ps2_byte, ps2_byte_valid     received byte stream from the PS/2 controller
//   key_held                     bit i = key slot i currently held
//   evt_valid/evt_key/evt_make   FIFO head (first-word fall-through), popped on evt_valid & evt_ready
//   evt_ready                    consumer pop request
//   fifo_overflow                sticky flag, an event was dropped
//   last_code                    last completed code {ext, byte}
module ps2_key_tracker #(
   parameter int                    NUM_KEYS       = 4,
   parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h172, 9'h175, 9'h01B, 9'h01D},
   parameter int                    FIFO_DEPTH     = 8,
   parameter int                    TIMEOUT_CYCLES = 50000,
   parameter int                    KW             = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic                inclock,
   input  logic                resetn,
   input  logic [7:0]          ps2_byte,
   input  logic                ps2_byte_valid,
   output logic [NUM_KEYS-1:0] key_held,
   output logic                evt_valid,
   output logic [KW-1:0]       evt_key,
   output logic                evt_make,
   input  logic                evt_ready,
   output logic                fifo_overflow,
   output logic [8:0]          last_code
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;
   state_t              state_q, state_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic                done, ext, brk;
   logic [8:0]          code, last_q;
   logic                hit;
   logic [KW-1:0]       idx;
   logic [NUM_KEYS-1:0] held_q, held_d;
   logic                push, pop, full, wr, ovf_q;
   logic [AW-1:0]       wptr_q, rptr_q, rptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [KW:0]         mem_q [FIFO_DEPTH];
   logic [KW:0]         entry, head_q, head_d;
   logic                hv_q;
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      done    = 1'b0;
      ext     = 1'b0;
      brk     = 1'b0;
      if (ps2_byte_valid) begin
         tmo_d = '0;
         unique case (state_q)
            IDLE:    begin
               state_d = (ps2_byte == 8'hE0) ? EXT : (ps2_byte == 8'hF0) ? BRK : IDLE;
               done    = ps2_byte != 8'hE0 && ps2_byte != 8'hF0 && ps2_byte != 8'hE1;
            end
            EXT:     begin
               state_d = (ps2_byte == 8'hF0) ? EXTBRK : EXT;
               done    = ps2_byte != 8'hF0 && ps2_byte != 8'hE0;
               ext     = 1'b1;
            end
            BRK:     begin
               done = 1'b1;
               brk  = 1'b1;
            end
            EXTBRK:  begin
               done = 1'b1;
               ext  = 1'b1;
               brk  = 1'b1;
            end
         endcase
         if (done) state_d = IDLE;
      end else if (state_q != IDLE) begin
         // the idle cycle that brings the count to TIMEOUT_CYCLES abandons the prefix
         state_d = (tmo_q == TW'(TIMEOUT_CYCLES - 1)) ? IDLE : state_q;
         tmo_d   = (tmo_q == TW'(TIMEOUT_CYCLES - 1)) ? '0 : tmo_q + 1'b1;
      end
   end
   assign code = {ext, ps2_byte};
   // scan downward so the lowest matching slot is the one left standing
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--)
         if (KEY_CODES[9*i +: 9] == code) begin
            hit = 1'b1;
            idx = KW'(i);
         end
   end
   // an event only when the held bit actually flips, which swallows typematic repeats
   assign push = done && hit && (held_q[idx] == brk);
   always_comb begin
      held_d = held_q;
      if (done && hit) held_d[idx] = ~brk;
   end
   assign entry  = {idx, ~brk};
   assign pop    = hv_q & evt_ready;
   assign full   = cnt_q == CW'(FIFO_DEPTH);
   assign wr     = push & (~full | pop);
   assign rptr_d = rptr_q + AW'(pop);
   assign cnt_d  = cnt_q + CW'(wr) - CW'(pop);
   // the entry being written this cycle becomes head when it lands where the read pointer will be
   assign head_d = (wr && wptr_q == rptr_d) ? entry : mem_q[rptr_d];
   always_ff @(posedge inclock)
      if (wr) mem_q[wptr_q] <= entry;
   always_ff @(posedge inclock) begin
      if (!resetn) begin
         state_q <= IDLE;
         tmo_q   <= '0;
         last_q  <= '0;
         held_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         head_q  <= '0;
         hv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         last_q  <= done ? code : last_q;
         held_q  <= held_d;
         wptr_q  <= wptr_q + AW'(wr);
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_q | (push & full & ~pop);
         head_q  <= head_d;
         hv_q    <= cnt_d != '0;
      end
   end
   assign key_held      = held_q;
   assign evt_valid     = hv_q;
   assign evt_key       = head_q[KW:1];
   assign evt_make      = head_q[0];
   assign fifo_overflow = ovf_q;
   assign last_code     = last_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed vector bench for ps2_key_tracker
module tb_ps2_key_tracker;
   localparam int T = 20;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] ps2_byte = '0;
   logic       ps2_byte_valid = 1'b0;
   logic [3:0] key_held;
   logic       evt_valid;
   logic [1:0] evt_key;
   logic       evt_make;
   logic       evt_ready = 1'b0;
   logic       fifo_overflow;
   logic [8:0] last_code;
   int         total = 0;
   int         bad = 0;
   typedef struct {
      logic [7:0] b;
      logic [3:0] held;
      logic [8:0] last;
   } vec_t;
   typedef struct {
      logic [1:0] key;
      logic       mk;
   } evt_t;
   vec_t tv [22];
   evt_t ev [8];
   ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
      .inclock(clk), .resetn(resetn), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_byte_valid),
      .key_held(key_held), .evt_valid(evt_valid), .evt_key(evt_key), .evt_make(evt_make),
      .evt_ready(evt_ready), .fifo_overflow(fifo_overflow), .last_code(last_code)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask
   task automatic send(input logic [7:0] b, input logic r);
      @(negedge clk);
      ps2_byte = b;
      ps2_byte_valid = 1'b1;
      evt_ready = r;
      @(negedge clk);
      ps2_byte_valid = 1'b0;
      evt_ready = 1'b0;
   endtask
   task automatic pop_chk(input string name, input logic [1:0] k, input logic m);
      chk({name, " valid"}, 32'(evt_valid), 32'(1'b1));
      chk({name, " key"}, 32'(evt_key), 32'(k));
      chk({name, " make"}, 32'(evt_make), 32'(m));
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask
   task automatic chk_reset(input string name);
      chk({name, " held"}, 32'(key_held), 32'h0);
      chk({name, " evt_valid"}, 32'(evt_valid), 32'h0);
      chk({name, " evt_key"}, 32'(evt_key), 32'h0);
      chk({name, " evt_make"}, 32'(evt_make), 32'h0);
      chk({name, " ovf"}, 32'(fifo_overflow), 32'h0);
      chk({name, " last"}, 32'(last_code), 32'h0);
   endtask
   initial begin
      tv = '{
         '{8'h1D, 4'b0001, 9'h01D}, '{8'hF0, 4'b0001, 9'h01D}, '{8'h1D, 4'b0000, 9'h01D},
         '{8'hE0, 4'b0000, 9'h01D}, '{8'h75, 4'b0100, 9'h175}, '{8'hE0, 4'b0100, 9'h175},
         '{8'hF0, 4'b0100, 9'h175}, '{8'h75, 4'b0000, 9'h175}, '{8'h75, 4'b0000, 9'h075},
         '{8'h1B, 4'b0010, 9'h01B}, '{8'h1B, 4'b0010, 9'h01B}, '{8'h1B, 4'b0010, 9'h01B},
         '{8'h1B, 4'b0010, 9'h01B}, '{8'h1B, 4'b0010, 9'h01B}, '{8'hF0, 4'b0010, 9'h01B},
         '{8'h1B, 4'b0000, 9'h01B}, '{8'hE1, 4'b0000, 9'h01B}, '{8'hE0, 4'b0000, 9'h01B},
         '{8'h72, 4'b1000, 9'h172}, '{8'hE0, 4'b1000, 9'h172}, '{8'hF0, 4'b1000, 9'h172},
         '{8'h72, 4'b0000, 9'h172}
      };
      ev = '{'{2'd0, 1'b0}, '{2'd2, 1'b1}, '{2'd2, 1'b0}, '{2'd1, 1'b1},
             '{2'd1, 1'b0}, '{2'd3, 1'b1}, '{2'd3, 1'b0}, '{2'd0, 1'b1}};
      repeat (3) @(negedge clk);
      chk_reset("reset");
      resetn = 1'b1;
      // eight held-bit flips fill the FIFO exactly while nothing is popped
      for (int i = 0; i < 22; i++) begin
         send(tv[i].b, 1'b0);
         chk($sformatf("vec%0d held", i), 32'(key_held), 32'(tv[i].held));
         chk($sformatf("vec%0d last", i), 32'(last_code), 32'(tv[i].last));
      end
      chk("full head valid", 32'(evt_valid), 32'h1);
      chk("full head key", 32'(evt_key), 32'h0);
      chk("full head make", 32'(evt_make), 32'h1);
      chk("full no ovf", 32'(fifo_overflow), 32'h0);
      // push and pop together while full: no drop, head advances
      send(8'h1D, 1'b1);
      chk("fullpp held", 32'(key_held), 32'b0001);
      chk("fullpp ovf", 32'(fifo_overflow), 32'h0);
      chk("fullpp head key", 32'(evt_key), 32'h0);
      chk("fullpp head make", 32'(evt_make), 32'h0);
      // push while full without a pop: dropped, sticky overflow, held still updates
      send(8'hF0, 1'b0);
      send(8'h1D, 1'b0);
      chk("drop held", 32'(key_held), 32'b0000);
      chk("drop ovf", 32'(fifo_overflow), 32'h1);
      for (int i = 0; i < 8; i++) pop_chk($sformatf("drain%0d", i), ev[i].key, ev[i].mk);
      chk("drained valid", 32'(evt_valid), 32'h0);
      chk("drained ovf sticky", 32'(fifo_overflow), 32'h1);
      // push and pop together with one entry: new entry becomes head
      send(8'h1D, 1'b0);
      chk("one valid", 32'(evt_valid), 32'h1);
      send(8'hF0, 1'b0);
      send(8'h1D, 1'b1);
      pop_chk("one pp", 2'd0, 1'b0);
      chk("one pp empty", 32'(evt_valid), 32'h0);
      // prefix abandoned after the idle timeout
      send(8'hE0, 1'b0);
      repeat (T + 2) @(negedge clk);
      send(8'h72, 1'b0);
      chk("tmo last", 32'(last_code), 32'h072);
      chk("tmo held", 32'(key_held), 32'b0000);
      chk("tmo no evt", 32'(evt_valid), 32'h0);
      // just short of the timeout the prefix survives
      send(8'hE0, 1'b0);
      repeat (T - 2) @(negedge clk);
      send(8'h72, 1'b0);
      chk("notmo last", 32'(last_code), 32'h172);
      chk("notmo held", 32'(key_held), 32'b1000);
      pop_chk("notmo evt", 2'd3, 1'b1);
      // reset in the middle of a break prefix
      send(8'hF0, 1'b0);
      resetn = 1'b0;
      @(negedge clk);
      chk_reset("midreset");
      resetn = 1'b1;
      send(8'h1D, 1'b0);
      chk("post reset held", 32'(key_held), 32'b0001);
      chk("post reset last", 32'(last_code), 32'h01D);
      pop_chk("post reset evt", 2'd0, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
